// File: rtl/nios_cpu_debug_ocimem_ctrl.sv
// Debug monitor memory controller.
// Serves JTAG debug-slave commands (address load, write with auto-increment,
// read with auto-increment) and a CPU-side Avalon-MM slave port against one
// single-port 32-bit debug RAM. JTAG always wins arbitration.
//
// Handshake: the CPU holds avs_read/avs_write (and address/data) stable until
// a cycle with avs_waitrequest=0; that cycle completes the transfer, and for
// reads avs_readdata is valid in that same cycle. JTAG strobes are one-cycle
// pulses with no back-pressure: a strobe arriving while the controller is not
// IDLE is dropped and recorded in the sticky cmd_overrun flag.
module nios_cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int JDO_ADDR_LSB = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              cmd_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    J_RD   = 3'd1,
    J_CAP  = 3'd2,
    C_RD   = 3'd3,
    C_DONE = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;

  logic              strobe_any;
  logic              in_idle;
  logic              jtag_wr;
  logic              cpu_wr_go;

  // jdo bits outside the address and data fields carry nothing for this block.
  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign in_idle    = (state == IDLE);
  // ocimem_b only acts when ocimem_a is not also present.
  assign jtag_wr    = in_idle & ~take_action_ocimem_a & take_action_ocimem_b;
  // A simultaneous read wins over a write; any JTAG strobe defers the CPU.
  assign cpu_wr_go  = in_idle & ~strobe_any & avs_write & ~avs_read;
  assign jtag_busy  = (state == J_RD) || (state == J_CAP);

  // RAM port steering: JTAG address during JTAG activity, CPU address otherwise.
  // Addressing the CPU location while IDLE lets C_RD capture the data directly.
  always_comb begin
    ram_addr  = avs_address;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_wdata = 32'h0;
    if ((state == J_RD) || (in_idle && strobe_any)) begin
      ram_addr = addr;
    end
    if (!reset && jtag_wr) begin
      ram_we    = 1'b1;
      ram_be    = 4'hF;
      ram_wdata = jdo[34:3];
    end else if (!reset && cpu_wr_go) begin
      ram_we    = 1'b1;
      ram_be    = avs_byteenable;
      ram_wdata = avs_writedata;
    end
  end

  // Single-port RAM: byte-enabled write, registered read every cycle, no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && ram_be[i]) begin
        mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    ram_q <= mem[ram_addr];
  end

  // CPU stall: released only in C_DONE or for an accepted IDLE write.
  always_comb begin
    avs_waitrequest = 1'b1;
    if (reset || strobe_any) begin
      avs_waitrequest = 1'b1;
    end else if (state == C_DONE) begin
      avs_waitrequest = 1'b0;
    end else if (cpu_wr_go) begin
      avs_waitrequest = 1'b0;
    end
  end

  // Controller FSM with address pointer, overrun flag and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      MonDReg      <= 32'h0;
      avs_readdata <= 32'h0;
      cmd_overrun  <= 1'b0;
    end else begin
      if (!in_idle && strobe_any) begin
        cmd_overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (take_action_ocimem_a) begin
            addr        <= jdo[JDO_ADDR_LSB +: ADDR_W];
            cmd_overrun <= 1'b0;
            if (jdo[35]) begin
              state <= J_RD;
            end
          end else if (take_action_ocimem_b) begin
            addr <= addr + ADDR_W'(1);
          end else if (take_no_action_ocimem_a) begin
            state <= J_RD;
          end else if (avs_read) begin
            state <= C_RD;
          end
        end
        J_RD: begin
          state <= J_CAP;
        end
        J_CAP: begin
          MonDReg <= ram_q;
          addr    <= addr + ADDR_W'(1);
          state   <= IDLE;
        end
        C_RD: begin
          avs_readdata <= ram_q;
          state        <= C_DONE;
        end
        C_DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
